mips_multicycle_ctrl: RTL

Multicycle MIPS control unit that drives the ALU's 3-bit function select and consumes its zero flag.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Emits datapath enables and mux selects.
- Sits between the instruction register (op/funct) and the shared ALU/register-file/memory datapath.

---
 rtl/mips_ctrl_pkg.sv | 45 ++++
 rtl/mips_multicycle_ctrl_if.sv | 23 ++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 26 ++
 rtl/mips_multicycle_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// MIPS_CTRL_BNE_EN adds bne (op 000101) to the supported opcode set.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
    ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // NONE marks states that do not use the ALU, so alucontrol reads 000 there
  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10, ALUOP_NONE = 2'b11
  } aluop_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
`ifdef MIPS_CTRL_BNE_EN
      OP_BNE: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and zero in, enables and selects out.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, alusrca;
  logic [1:0] alusrcb;
  logic       memtoreg, regdst;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       instr_done, illegal;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
           memtoreg, regdst, pcsrc, alucontrol, instr_done, illegal
  );
  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
           memtoreg, regdst, pcsrc, alucontrol, instr_done, illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational ALU function select from aluop and R-type funct.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol
);
  always_comb begin
    alucontrol = ALU_AND;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT:
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_AND;
        endcase
      default:   alucontrol = ALU_AND;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with Moore outputs; pcen alone also looks at zero.
// MIPS_CTRL_BNE_EN enables bne through the shared BRANCH state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mips_multicycle_ctrl_if.master bus
);
  state_t     state, next, cur;
  aluop_t     aluop;
  logic       pcwrite, branch, brcond;
  logic [2:0] alucontrol;

  always_ff @(posedge clk)
    if (!reset_n) state <= FETCH;
    else          state <= next;

`ifdef MIPS_CTRL_BNE_EN
  logic bne_q;
  always_ff @(posedge clk)
    if (!reset_n)            bne_q <= 1'b0;
    else if (state == DECODE) bne_q <= (bus.op == OP_BNE);
  assign brcond = bne_q ? ~bus.zero : bus.zero;
`else
  assign brcond = bus.zero;
`endif

  always_comb begin
    next = state;
    case (state)
      FETCH:    next = DECODE;
      DECODE:
        if (!op_supported(bus.op)) next = HALT_ON_ILLEGAL ? HALT : FETCH;
        else
          case (bus.op)
            OP_LW, OP_SW:     next = MEMADR;
            OP_RTYPE:         next = EXECUTE;
            OP_ADDI:          next = ADDIEXEC;
            OP_J:             next = JUMP;
            default:          next = BRANCH;
          endcase
      MEMADR:   next = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    next = MEMWB;
      EXECUTE:  next = ALUWB;
      ADDIEXEC: next = ADDIWB;
      HALT:     next = HALT;
      default:  next = FETCH;
    endcase
  end

  alu_decoder u_aludec (.aluop(aluop), .funct(bus.funct), .alucontrol(alucontrol));

  // While reset is asserted the outputs look like FETCH with every enable masked
  assign cur = reset_n ? state : FETCH;

  always_comb begin
    pcwrite        = 1'b0;
    branch         = 1'b0;
    aluop          = ALUOP_NONE;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regwrite   = 1'b0;
    bus.iord       = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.memtoreg   = 1'b0;
    bus.regdst     = 1'b0;
    bus.pcsrc      = 2'b00;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    case (cur)
      FETCH:    begin bus.irwrite = 1'b1; pcwrite = 1'b1; bus.alusrcb = 2'b01; aluop = ALUOP_ADD; end
      DECODE:   begin bus.alusrcb = 2'b11; aluop = ALUOP_ADD; bus.illegal = ~op_supported(bus.op); end
      MEMADR:   begin bus.alusrca = 1'b1; bus.alusrcb = 2'b10; aluop = ALUOP_ADD; end
      MEMRD:    bus.iord = 1'b1;
      MEMWB:    begin bus.memtoreg = 1'b1; bus.regwrite = 1'b1; bus.instr_done = 1'b1; end
      MEMWR:    begin bus.iord = 1'b1; bus.memwrite = 1'b1; bus.instr_done = 1'b1; end
      EXECUTE:  begin bus.alusrca = 1'b1; aluop = ALUOP_FUNCT; end
      ALUWB:    begin bus.regdst = 1'b1; bus.regwrite = 1'b1; bus.instr_done = 1'b1; end
      BRANCH:   begin
        bus.alusrca = 1'b1; aluop = ALUOP_SUB; bus.pcsrc = 2'b01;
        branch = 1'b1; bus.instr_done = 1'b1;
      end
      ADDIEXEC: begin bus.alusrca = 1'b1; bus.alusrcb = 2'b10; aluop = ALUOP_ADD; end
      ADDIWB:   begin bus.regwrite = 1'b1; bus.instr_done = 1'b1; end
      JUMP:     begin bus.pcsrc = 2'b10; pcwrite = 1'b1; bus.instr_done = 1'b1; end
      default:  ;
    endcase
    if (!reset_n) begin
      pcwrite        = 1'b0;
      branch         = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.regwrite   = 1'b0;
      bus.instr_done = 1'b0;
      bus.illegal    = 1'b0;
    end
  end

  assign bus.pcen       = pcwrite | (branch & brcond);
  assign bus.alucontrol = alucontrol;

endmodule
